// File: rtl/flash_rd_pkg.sv
// Shared types and constants for the NOR flash read controller.
// FSM state encoding, counter width and fixed levels for the unused flash control pins.
package flash_rd_pkg;

   typedef enum logic [2:0] {
      ST_RST,
      ST_RDY,
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_REC
   } state_t;

   localparam int CNT_W = 5;

   localparam logic TIE_WE_N   = 1'b1;
   localparam logic TIE_BYTE_N = 1'b1;
   localparam logic TIE_WP_N   = 1'b0;

endpackage

// File: rtl/flash_rd_ctrl_if.sv
// Cart ROM bus between the decoder (master) and flash_rd_ctrl (slave).
// Also carries the controller's FSM state for observation.
interface flash_rd_ctrl_if #(
   parameter int ADDR_W = 22
);
   import flash_rd_pkg::*;

   // req is held high with addr stable until ack, a one-cycle pulse with rdata
   // valid in that same cycle; req must be low in the cycle after ack.
   logic              req;
   logic [ADDR_W-1:0] addr;
   logic              ack;
   logic [15:0]       rdata;
   logic              busy;
   logic              inval;
   state_t            dbg_state;

   modport master (
      output req, addr, inval,
      input  ack, rdata, busy, dbg_state
   );

   modport slave (
      input  req, addr, inval,
      output ack, rdata, busy, dbg_state
   );

endinterface

// File: rtl/flash_rd_buf.sv
// One-entry last-word buffer: stores address/data of the last flash read.
// inval clears the entry immediately and overrides a same-cycle write.
module flash_rd_buf #(
   parameter int ADDR_W = 22
) (
   input  logic              clk50,
   input  logic              rst,
   input  logic              i_inval,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [15:0]       i_wr_data,
   input  logic [ADDR_W-1:0] i_lookup_addr,
   output logic              o_hit,
   output logic [15:0]       o_rd_data
);

   logic              r_valid;
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_data;

   always_ff @(posedge clk50) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
      end else begin
         if (i_wr_en) begin
            r_addr <= i_wr_addr;
            r_data <= i_wr_data;
         end
         if (i_inval)
            r_valid <= 1'b0;
         else if (i_wr_en)
            r_valid <= 1'b1;
      end
   end

   // A pulse on inval already blocks a hit in the cycle it is asserted.
   assign o_hit     = r_valid && !i_inval && (i_lookup_addr == r_addr);
   assign o_rd_data = r_data;

endmodule

// File: rtl/flash_rd_ctrl.sv
// Read-side controller for the 16-bit parallel NOR flash: timed CE#/OE# cycles
// with a last-word buffer. Optional macro FLASH_BYTESWAP_EN swaps the bytes of captured data.
module flash_rd_ctrl
   import flash_rd_pkg::*;
#(
   parameter int ADDR_W   = 22,
   parameter int TACC_CYC = 5,
   parameter int TREC_CYC = 1,
   parameter int RST_CYC  = 25,
   parameter int RDY_CYC  = 10
) (
   input  logic              clk50,
   input  logic              rst,
   flash_rd_ctrl_if.slave    bus,
   output logic [ADDR_W-1:0] FL_ADDR,
   input  logic [15:0]       FL_DQ,
   output logic              FL_CE_N,
   output logic              FL_OE_N,
   output logic              FL_WE_N,
   output logic              FL_BYTE_N,
   output logic              FL_WP_N,
   output logic              FL_RST_N
);

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_ack;
   logic [15:0]       r_rdata;
   logic              r_busy;
   logic [ADDR_W-1:0] r_fl_addr;
   logic              r_ce_n;
   logic              r_oe_n;
   logic              r_rst_n;
   logic              r_keep;

   logic              w_hit;
   logic [15:0]       w_buf_data;
   logic [15:0]       w_cap_data;
   logic              w_cap;

`ifdef FLASH_BYTESWAP_EN
   assign w_cap_data = {FL_DQ[7:0], FL_DQ[15:8]};
`else
   assign w_cap_data = FL_DQ;
`endif

   assign w_cap = (r_state == ST_ACCESS) && (r_cnt == '0);

   flash_rd_buf #(.ADDR_W(ADDR_W)) u_buf (
      .clk50         (clk50),
      .rst           (rst),
      .i_inval       (bus.inval),
      .i_wr_en       (w_cap),
      .i_wr_addr     (r_fl_addr),
      .i_wr_data     (w_cap_data),
      .i_lookup_addr (bus.addr),
      .o_hit         (w_hit),
      .o_rd_data     (w_buf_data)
   );

   always_ff @(posedge clk50) begin
      if (rst) begin
         r_state   <= ST_RST;
         r_cnt     <= '0;
         r_ack     <= 1'b0;
         r_rdata   <= '0;
         r_busy    <= 1'b1;
         r_fl_addr <= '0;
         r_ce_n    <= 1'b1;
         r_oe_n    <= 1'b1;
         r_rst_n   <= 1'b0;
         r_keep    <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            ST_RST: begin
               if (r_cnt == CNT_W'(RST_CYC - 1)) begin
                  r_state <= ST_RDY;
                  r_cnt   <= '0;
                  r_rst_n <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_RDY: begin
               if (r_cnt == CNT_W'(RDY_CYC - 1)) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_IDLE: begin
               if (bus.req) begin
                  if (w_hit) begin
                     r_ack   <= 1'b1;
                     r_rdata <= w_buf_data;
                  end else begin
                     // Address and strobes move together so FL_ADDR is stable for the whole strobe.
                     r_fl_addr <= bus.addr;
                     r_ce_n    <= 1'b0;
                     r_oe_n    <= 1'b0;
                     r_busy    <= 1'b1;
                     r_keep    <= 1'b1;
                     r_state   <= ST_SETUP;
                  end
               end
            end
            ST_SETUP: begin
               r_cnt   <= CNT_W'(TACC_CYC - 1);
               r_state <= ST_ACCESS;
               if (!bus.req)
                  r_keep <= 1'b0;
            end
            ST_ACCESS: begin
               if (r_cnt == '0) begin
                  r_rdata <= w_cap_data;
                  r_ack   <= r_keep && bus.req;
                  r_ce_n  <= 1'b1;
                  r_oe_n  <= 1'b1;
                  r_cnt   <= CNT_W'(TREC_CYC - 1);
                  r_state <= ST_REC;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
                  if (!bus.req)
                     r_keep <= 1'b0;
               end
            end
            ST_REC: begin
               if (r_cnt == '0) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: r_state <= ST_RST;
         endcase
      end
   end

   assign bus.ack       = r_ack;
   assign bus.rdata     = r_rdata;
   assign bus.busy      = r_busy;
   assign bus.dbg_state = r_state;

   assign FL_ADDR   = r_fl_addr;
   assign FL_CE_N   = r_ce_n;
   assign FL_OE_N   = r_oe_n;
   assign FL_RST_N  = r_rst_n;
   assign FL_WE_N   = TIE_WE_N;
   assign FL_BYTE_N = TIE_BYTE_N;
   assign FL_WP_N   = TIE_WP_N;

endmodule

// File: tb/tb_flash_rd_ctrl.sv
// Self-checking bench for flash_rd_ctrl: directed plan items plus random reads
// against a memory/buffer reference model. Honours FLASH_BYTESWAP_EN.
module tb_flash_rd_ctrl;

   localparam int ADDR_W   = 22;
   localparam int TACC_CYC = 5;
   localparam int TREC_CYC = 1;
   localparam int RST_CYC  = 25;
   localparam int RDY_CYC  = 10;
   localparam int TMO      = 80;

   logic              clk50;
   logic              rst;
   logic [ADDR_W-1:0] fl_addr;
   logic [15:0]       fl_dq;
   logic              fl_ce_n, fl_oe_n, fl_we_n, fl_byte_n, fl_wp_n, fl_rst_n;

   flash_rd_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   flash_rd_ctrl #(
      .ADDR_W(ADDR_W), .TACC_CYC(TACC_CYC), .TREC_CYC(TREC_CYC),
      .RST_CYC(RST_CYC), .RDY_CYC(RDY_CYC)
   ) dut (
      .clk50     (clk50),
      .rst       (rst),
      .bus       (bus),
      .FL_ADDR   (fl_addr),
      .FL_DQ     (fl_dq),
      .FL_CE_N   (fl_ce_n),
      .FL_OE_N   (fl_oe_n),
      .FL_WE_N   (fl_we_n),
      .FL_BYTE_N (fl_byte_n),
      .FL_WP_N   (fl_wp_n),
      .FL_RST_N  (fl_rst_n)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk50 = 1'b0;
      forever #10 clk50 = ~clk50;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- flash memory model ----------------
   function automatic logic [15:0] raw_word(input logic [ADDR_W-1:0] a);
      case (a)
         22'h000100: return 16'h1234;
         22'h003FFF: return 16'hA55A;
         default:    return a[15:0] ^ {a[21:16], 10'h2B7};
      endcase
   endfunction

   function automatic logic [15:0] model_word(input logic [ADDR_W-1:0] a);
      logic [15:0] w;
      w = raw_word(a);
`ifdef FLASH_BYTESWAP_EN
      return {w[7:0], w[15:8]};
`else
      return w;
`endif
   endfunction

   // Data is only valid once CE#/OE# have been low for the access time.
   int low_cnt = 0;
   always @(posedge clk50) begin
      if (!fl_ce_n && !fl_oe_n) low_cnt <= low_cnt + 1;
      else                      low_cnt <= 0;
   end
   assign fl_dq = (low_cnt >= TACC_CYC) ? raw_word(fl_addr) : 16'hDEAD;

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [15:0] exp_q[$];

   bit                m_valid = 1'b0;
   logic [ADDR_W-1:0] m_addr  = '0;
   logic [15:0]       m_data  = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic sb_pop();
      if (exp_q.size() == 0) check("sb_unexpected_ack", 1, 0);
      else                   check("rdata", {16'h0, bus.rdata}, {16'h0, exp_q.pop_front()});
   endtask

   task automatic tick();
      @(posedge clk50);
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic reset_seq();
      int rst_n_at, idle_at, ce_lo;
      rst = 1'b1;
      bus.req = 1'b0;
      bus.inval = 1'b0;
      tick();
      check("rst_ack", bus.ack, 0);
      check("rst_rdata", bus.rdata, 0);
      check("rst_busy", bus.busy, 1);
      check("rst_fl_addr", fl_addr, 0);
      check("rst_ce_n", fl_ce_n, 1);
      check("rst_oe_n", fl_oe_n, 1);
      check("rst_fl_rst_n", fl_rst_n, 0);
      check("tie_offs", {fl_we_n, fl_byte_n, fl_wp_n}, 3'b110);
      tick();
      rst = 1'b0;
      rst_n_at = 0;
      idle_at = 0;
      ce_lo = 0;
      for (int n = 1; n <= RST_CYC + RDY_CYC + 20 && idle_at == 0; n++) begin
         tick();
         if (!fl_ce_n) ce_lo++;
         if (fl_rst_n && rst_n_at == 0) rst_n_at = n;
         if (!bus.busy) idle_at = n;
      end
      check("rst_low_cycles", rst_n_at, RST_CYC);
      check("busy_release", idle_at, RST_CYC + RDY_CYC);
      check("rst_ce_quiet", ce_lo, 0);
      m_valid = 1'b0;
   endtask

   task automatic do_inval();
      bus.inval = 1'b1;
      tick();
      bus.inval = 1'b0;
      m_valid = 1'b0;
   endtask

   // inval_at > 0 pulses inval so that it is sampled on the capture edge of a miss.
   task automatic do_read(input logic [ADDR_W-1:0] a, input int inval_at);
      bit          exp_hit;
      logic [15:0] exp_d;
      int          lat, ce_lo, k;
      exp_hit = m_valid && (a == m_addr);
      exp_d   = exp_hit ? m_data : model_word(a);
      exp_q.push_back(exp_d);
      bus.addr = a;
      bus.req  = 1'b1;
      lat = 0;
      ce_lo = 0;
      for (int n = 1; n <= TMO && lat == 0; n++) begin
         bus.inval = !exp_hit && (n == inval_at);
         tick();
         if (!fl_ce_n) ce_lo++;
         if (bus.ack) begin
            lat = n;
            bus.req = 1'b0;
            sb_pop();
            if (!exp_hit) check("fl_addr", fl_addr, a);
         end
      end
      bus.inval = 1'b0;
      bus.req = 1'b0;
      if (lat == 0) begin
         check("ack_timeout", 0, 1);
         void'(exp_q.pop_front());
      end
      check(exp_hit ? "hit_latency" : "miss_latency", lat, exp_hit ? 1 : TACC_CYC + 2);
      check(exp_hit ? "hit_ce_cycles" : "miss_ce_cycles", ce_lo, exp_hit ? 0 : TACC_CYC + 1);
      tick();
      check("ack_pulse", bus.ack, 0);
      k = 1;
      while (bus.busy && k < TMO) begin
         tick();
         k++;
      end
      check("back_to_idle", bus.busy, 0);
      if (!exp_hit) begin
         check("rec_cycles", k, TREC_CYC);
         m_valid = (inval_at == 0);
         m_addr  = a;
         m_data  = exp_d;
      end
   endtask

   task automatic do_abort(input logic [ADDR_W-1:0] a);
      int acks, k;
      bus.addr = a;
      bus.req  = 1'b1;
      acks = 0;
      for (int n = 1; n <= 4; n++) begin
         tick();
         if (bus.ack) acks++;
      end
      bus.req = 1'b0;
      k = 0;
      while (bus.busy && k < TMO) begin
         tick();
         if (bus.ack) acks++;
         k++;
      end
      check("abort_no_ack", acks, 0);
      check("abort_idle", bus.busy, 0);
      m_valid = 1'b1;
      m_addr  = a;
      m_data  = model_word(a);
   endtask

   task automatic do_rst_mid(input logic [ADDR_W-1:0] a);
      bus.addr = a;
      bus.req  = 1'b1;
      repeat (4) tick();
      check("mid_ce_low", fl_ce_n, 0);
      rst = 1'b1;
      tick();
      bus.req = 1'b0;
      check("mid_rst_ce_n", fl_ce_n, 1);
      check("mid_rst_oe_n", fl_oe_n, 1);
      check("mid_rst_fl_rst_n", fl_rst_n, 0);
      check("mid_rst_ack", bus.ack, 0);
      reset_seq();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [ADDR_W-1:0] pool[4];
      logic [ADDR_W-1:0] a;
      int                sel, ia;
      rst = 1'b1;
      bus.req = 1'b0;
      bus.addr = '0;
      bus.inval = 1'b0;

      reset_seq();

      do_read(22'h000100, 0);
      do_read(22'h000100, 0);
      do_inval();
      do_read(22'h000100, 0);
      do_read(22'h000100, 0);

      do_read(22'h000200, TACC_CYC + 2);
      do_read(22'h000200, 0);
      do_read(22'h000200, 0);

      do_abort(22'h000300);
      do_read(22'h000300, 0);

      do_read(22'h003FFF, 0);
      do_read(22'h003FFF, 0);
`ifdef FLASH_BYTESWAP_EN
      check("byteswap_model", model_word(22'h003FFF), 16'h5AA5);
`endif

      do_rst_mid(22'h000400);
      do_read(22'h000400, 0);

      pool[0] = 22'h000100;
      pool[1] = 22'h003FFF;
      pool[2] = 22'h00002A;
      pool[3] = 22'h3FFFFF;
      for (int i = 0; i < 30; i++) begin
         sel = $urandom_range(0, 4);
         a = (sel == 4) ? ADDR_W'($urandom_range(0, 32'h3FFFFF)) : pool[sel];
         case ($urandom_range(0, 5))
            0:       begin do_inval(); ia = 0; end
            1:       ia = TACC_CYC + 2;
            default: ia = 0;
         endcase
         do_read(a, ia);
         repeat ($urandom_range(0, 2)) tick();
      end

      check("sb_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/flash_rd_ctrl.md
Name: flash_rd_ctrl

Overview:
- Read-side initiator for the board's 16-bit parallel NOR flash (FL_* pins), used for cart ROM fetches.
- Converts a single-word req/ack bus request into a timed CE#/OE# read cycle and returns the captured FL_DQ word.
- Sits between the cart ROM bus decoder and the FL_* top-level pins.
- Includes a one-entry last-word buffer so repeated reads of the same word do not re-cycle the flash.

Parameters:
- ADDR_W, 22, word address width (drives FL_ADDR).
- TACC_CYC, 5, clk50 cycles with CE#/OE# low before sampling FL_DQ; range 1..15.
- TREC_CYC, 1, clk50 cycles with CE#/OE# high between accesses; range 1..7.
- RST_CYC, 25, cycles FL_RST_N is held low after rst.
- RDY_CYC, 10, cycles after FL_RST_N rises before the first access.

Ports:
- clk50  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- req  in  1  read request; held high until ack.
- addr  in  ADDR_W  word address; stable while req is high.
- ack  out  1  one-cycle pulse; rdata is valid in the same cycle.
- rdata  out  16  read data.
- busy  out  1  high while not in IDLE.
- inval  in  1  one-cycle pulse that invalidates the last-word buffer.
- FL_ADDR  out  ADDR_W  flash address.
- FL_DQ  in  16  flash data. The block never drives this bus.
- FL_CE_N, FL_OE_N  out  1  chip enable and output enable, active low.
- FL_WE_N, FL_BYTE_N, FL_WP_N  out  1  tied to 1, 1 and 0 respectively.
- FL_RST_N  out  1  flash reset, active low.

Behaviour:
- Reset (sync, active-high) values:
  - ack=0, rdata=0, busy=1, FL_ADDR=0, FL_CE_N=1, FL_OE_N=1, FL_RST_N=0.
  - buffer valid bit cleared; state=RST; counter=0.
- States:
  - RST: FL_RST_N=0 for RST_CYC cycles, then go to RDY.
  - RDY: FL_RST_N=1, wait RDY_CYC cycles, then go to IDLE.
  - IDLE: busy=0.
    - req with buffer valid and addr==buf_addr (hit): ack=1 and rdata=buf_data in the next cycle; stay in IDLE.
    - req otherwise: latch FL_ADDR<=addr, go to SETUP.
  - SETUP: FL_CE_N=0, FL_OE_N=0, counter<=TACC_CYC-1, go to ACCESS.
  - ACCESS: decrement counter. At 0, sample FL_DQ into rdata and the buffer, set buf_addr=FL_ADDR, valid=1, ack=1, FL_CE_N=FL_OE_N=1, go to REC.
  - REC: hold TREC_CYC cycles, then go to IDLE.
- Latency:
  - Miss: ack is asserted TACC_CYC+2 cycles after req is sampled in IDLE.
  - Hit: ack is asserted 1 cycle after req.
  - A back-to-back miss costs TACC_CYC+TREC_CYC+2 cycles per word.
- Handshake:
  - ack is a single-cycle pulse.
  - The requester drops req in the ack cycle or later. Because ack is registered, req must be low in the cycle after ack.
  - req still high in IDLE after ack is treated as a new request (hit path).
  - A req dropped before ack aborts nothing: the cycle completes and the buffer is updated, but no ack is issued.
- inval:
  - Clears the valid bit in the same cycle.
  - If inval coincides with the ACCESS capture, inval wins: the buffer stays invalid, but ack and rdata are still returned.
  - inval during RST/RDY has no additional effect.
- Timing requirements:
  - FL_ADDR changes only in IDLE→SETUP, so the address is stable for TACC_CYC+1 cycles before capture.
  - FL_CE_N/FL_OE_N never glitch; both change only on clk50 edges.
- rst mid-access: all flash controls go inactive on the next edge, no ack is issued, and the RST sequence restarts.
- Address wrap: none. addr is used directly; the top bits beyond the device size are the caller's concern.

Optional Feature:
- FLASH_BYTESWAP_EN defined: captured data is stored and returned as {FL_DQ[7:0],FL_DQ[15:8]}. This supports images programmed with byte-swapped tools.
- Undefined: data is returned as FL_DQ[15:0] unchanged.
- Buffer hits return the already-swapped stored value, so no double swap occurs.

Decomposition:
- Package flash_rd_pkg holds:
  - state enum (RST, RDY, IDLE, SETUP, ACCESS, REC);
  - counter width constant CNT_W=5;
  - FL_WE_N/FL_BYTE_N/FL_WP_N tie-off constants.
- Sub-module flash_rd_buf: one-entry address/data/valid register with the hit compare and inval handling.
- The FSM stays in flash_rd_ctrl.

Test Plan:
- Reset sequence: assert rst for 2 cycles, then release. Required: FL_RST_N low for exactly 25 cycles, busy high until cycle 35, FL_CE_N=1 throughout.
- Miss read: memory model holds word 0x1234 at 0x000100; req with addr=0x000100. Required: FL_CE_N/FL_OE_N low for 6 cycles, ack at +7, rdata=0x1234.
- Hit read: repeat addr=0x000100 after REC. Required: ack 1 cycle after req, FL_CE_N stays high, rdata=0x1234.
- inval then re-read: pulse inval, then req addr=0x000100. Required: a full flash cycle runs. Separately, inval coinciding with the capture: the next same-address req still misses.
- Abort and reset mid-access:
  - req dropped during ACCESS → no ack, buffer updated.
  - rst during ACCESS → FL_CE_N=1 on the next edge and FL_RST_N=0.
- Byteswap with FLASH_BYTESWAP_EN defined: memory word 0xA55A at 0x3FFF. Required: rdata=0x5AA5 on both the miss and the following hit.
